// File: rtl/fg_prog_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fg_prog_sequencer
// Description : Programs one floating-gate cell at a time in an island's
//               16x32 indirect FG matrix. It accepts a command, drives the
//               row/column decoder addresses and programming-switch enables,
//               and issues the Vinj injection pulses or a measure strobe.
//               Selects settle before the first pulse and are held through a
//               release interval after the last pulse or an abort.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, reset           : clock; asynchronous active-high reset
//   cmd_valid/cmd_ready  : command handshake (ready only while idle)
//   cmd_island/row/col   : target cell
//   cmd_op               : 0 = inject, 1 = measure
//   cmd_width/cmd_count  : pulse width in cycles (0 -> 1), number of pulses
//   abort                : terminate the current command through release
//   island_sel           : one-hot island enable
//   row_addr/col_addr    : vertical/horizontal decoder addresses
//   dec_en, gate_mux_en, drain_sel_en, prog_mode : select/switch enables
//   vinj_pulse           : injection pulse
//   meas_strobe          : one-cycle sample strobe at the end of a measure
//   busy, done, err, aborted : status; err/aborted are valid with done
// ============================================================================
module fg_prog_sequencer #(
    parameter int NUM_ISLANDS   = 2,
    parameter int NUM_ROWS      = 16,
    parameter int NUM_COLS      = 32,
    parameter int ADDR_BITS     = 6,
    parameter int SETTLE_CYCLES = 4,
    parameter int GAP_CYCLES    = 2,
    localparam int ISL_W = (NUM_ISLANDS > 1) ? $clog2(NUM_ISLANDS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [ISL_W-1:0]       cmd_island,
    input  logic [ADDR_BITS-1:0]   cmd_row,
    input  logic [ADDR_BITS-1:0]   cmd_col,
    input  logic                   cmd_op,
    input  logic [15:0]            cmd_width,
    input  logic [7:0]             cmd_count,
    input  logic                   abort,
    output logic [NUM_ISLANDS-1:0] island_sel,
    output logic [ADDR_BITS-1:0]   row_addr,
    output logic [ADDR_BITS-1:0]   col_addr,
    output logic                   dec_en,
    output logic                   gate_mux_en,
    output logic                   drain_sel_en,
    output logic                   prog_mode,
    output logic                   vinj_pulse,
    output logic                   meas_strobe,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic                   aborted
);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_SETUP   = 3'd1;
    localparam logic [2:0] c_ST_PULSE   = 3'd2;
    localparam logic [2:0] c_ST_GAP     = 3'd3;
    localparam logic [2:0] c_ST_MEAS    = 3'd4;
    localparam logic [2:0] c_ST_RELEASE = 3'd5;
    localparam logic [2:0] c_ST_DONE    = 3'd6;

    localparam logic [15:0] c_SETTLE_M1 = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] c_GAP_M1    = 16'(GAP_CYCLES - 1);

    logic [2:0]             r_state;
    logic [15:0]            r_cnt;          // cycles left in the current state, minus one
    logic [15:0]            r_width_m1;     // effective pulse/measure width minus one
    logic [7:0]             r_remaining;    // injection pulses still to issue
    logic                   r_op;
    logic                   r_abort_seen;
    logic [NUM_ISLANDS-1:0] r_island_sel;
    logic [ADDR_BITS-1:0]   r_row_addr;
    logic [ADDR_BITS-1:0]   r_col_addr;
    logic                   r_dec_en;
    logic                   r_gate_mux_en;
    logic                   r_drain_sel_en;
    logic                   r_prog_mode;
    logic                   r_vinj_pulse;
    logic                   r_meas_strobe;
    logic                   r_done;
    logic                   r_err;
    logic                   r_aborted;

    logic [NUM_ISLANDS-1:0] w_island_onehot;
    logic                   w_addr_bad;
    logic [15:0]            w_width_m1;
    logic                   w_abortable;

    for (genvar gi = 0; gi < NUM_ISLANDS; gi++) begin : g_isl_dec
        assign w_island_onehot[gi] = (cmd_island == ISL_W'(gi));
    end

    assign w_addr_bad  = (int'(cmd_row) >= NUM_ROWS) || (int'(cmd_col) >= NUM_COLS) ||
                         (int'(cmd_island) >= NUM_ISLANDS);
    // A zero width behaves as a single-cycle pulse.
    assign w_width_m1  = (cmd_width == 16'd0) ? 16'd0 : cmd_width - 16'd1;
    assign w_abortable = (r_state == c_ST_SETUP) || (r_state == c_ST_PULSE) ||
                         (r_state == c_ST_GAP)   || (r_state == c_ST_MEAS);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= c_ST_IDLE;
            r_cnt          <= '0;
            r_width_m1     <= '0;
            r_remaining    <= '0;
            r_op           <= 1'b0;
            r_abort_seen   <= 1'b0;
            r_island_sel   <= '0;
            r_row_addr     <= '0;
            r_col_addr     <= '0;
            r_dec_en       <= 1'b0;
            r_gate_mux_en  <= 1'b0;
            r_drain_sel_en <= 1'b0;
            r_prog_mode    <= 1'b0;
            r_vinj_pulse   <= 1'b0;
            r_meas_strobe  <= 1'b0;
            r_done         <= 1'b0;
            r_err          <= 1'b0;
            r_aborted      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (abort && w_abortable) begin
                // Pulse and strobe drop on this edge; selects stay up for release.
                r_state       <= c_ST_RELEASE;
                r_cnt         <= c_SETTLE_M1;
                r_vinj_pulse  <= 1'b0;
                r_meas_strobe <= 1'b0;
                r_abort_seen  <= 1'b1;
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        r_err     <= 1'b0;
                        r_aborted <= 1'b0;
                        if (cmd_valid) begin
                            r_op         <= cmd_op;
                            r_width_m1   <= w_width_m1;
                            r_remaining  <= cmd_count;
                            r_abort_seen <= 1'b0;
                            if (w_addr_bad) begin
                                // Bad address never touches the selects.
                                r_state <= c_ST_DONE;
                                r_done  <= 1'b1;
                                r_err   <= 1'b1;
                            end else begin
                                r_state        <= c_ST_SETUP;
                                r_cnt          <= c_SETTLE_M1;
                                r_island_sel   <= w_island_onehot;
                                r_row_addr     <= cmd_row;
                                r_col_addr     <= cmd_col;
                                r_dec_en       <= 1'b1;
                                r_gate_mux_en  <= 1'b1;
                                r_drain_sel_en <= ~cmd_op;
                                r_prog_mode    <= 1'b1;
                            end
                        end
                    end
                    c_ST_SETUP: begin
                        if (r_cnt != 16'd0) begin
                            r_cnt <= r_cnt - 16'd1;
                        end else if (r_op) begin
                            r_state       <= c_ST_MEAS;
                            r_cnt         <= r_width_m1;
                            r_meas_strobe <= (r_width_m1 == 16'd0);
                        end else if (r_remaining != 8'd0) begin
                            r_state      <= c_ST_PULSE;
                            r_cnt        <= r_width_m1;
                            r_vinj_pulse <= 1'b1;
                        end else begin
                            r_state <= c_ST_RELEASE;
                            r_cnt   <= c_SETTLE_M1;
                        end
                    end
                    c_ST_PULSE: begin
                        if (r_cnt != 16'd0) begin
                            r_cnt <= r_cnt - 16'd1;
                        end else begin
                            r_vinj_pulse <= 1'b0;
                            r_remaining  <= r_remaining - 8'd1;
                            if (r_remaining > 8'd1) begin
                                r_state <= c_ST_GAP;
                                r_cnt   <= c_GAP_M1;
                            end else begin
                                r_state <= c_ST_RELEASE;
                                r_cnt   <= c_SETTLE_M1;
                            end
                        end
                    end
                    c_ST_GAP: begin
                        if (r_cnt != 16'd0) begin
                            r_cnt <= r_cnt - 16'd1;
                        end else begin
                            r_state      <= c_ST_PULSE;
                            r_cnt        <= r_width_m1;
                            r_vinj_pulse <= 1'b1;
                        end
                    end
                    c_ST_MEAS: begin
                        if (r_cnt != 16'd0) begin
                            r_cnt         <= r_cnt - 16'd1;
                            // Registered strobe: raise it entering the final cycle.
                            r_meas_strobe <= (r_cnt == 16'd1);
                        end else begin
                            r_state       <= c_ST_RELEASE;
                            r_cnt         <= c_SETTLE_M1;
                            r_meas_strobe <= 1'b0;
                        end
                    end
                    c_ST_RELEASE: begin
                        if (r_cnt != 16'd0) begin
                            r_cnt <= r_cnt - 16'd1;
                        end else begin
                            r_state        <= c_ST_DONE;
                            r_done         <= 1'b1;
                            r_aborted      <= r_abort_seen;
                            r_island_sel   <= '0;
                            r_row_addr     <= '0;
                            r_col_addr     <= '0;
                            r_dec_en       <= 1'b0;
                            r_gate_mux_en  <= 1'b0;
                            r_drain_sel_en <= 1'b0;
                            r_prog_mode    <= 1'b0;
                        end
                    end
                    c_ST_DONE: begin
                        r_state   <= c_ST_IDLE;
                        r_err     <= 1'b0;
                        r_aborted <= 1'b0;
                    end
                    default: begin
                        r_state <= c_ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign cmd_ready    = (r_state == c_ST_IDLE);
    assign busy         = (r_state != c_ST_IDLE);
    assign island_sel   = r_island_sel;
    assign row_addr     = r_row_addr;
    assign col_addr     = r_col_addr;
    assign dec_en       = r_dec_en;
    assign gate_mux_en  = r_gate_mux_en;
    assign drain_sel_en = r_drain_sel_en;
    assign prog_mode    = r_prog_mode;
    assign vinj_pulse   = r_vinj_pulse;
    assign meas_strobe  = r_meas_strobe;
    assign done         = r_done;
    assign err          = r_err;
    assign aborted      = r_aborted;

endmodule
`default_nettype wire

// File: tb/tb_fg_prog_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fg_prog_sequencer
// Description : Self-checking bench for fg_prog_sequencer. Expected outputs
//               for every cycle of a command are computed from the command's
//               timeline (settle, pulses, gaps, measure, release, done).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fg_prog_sequencer;

    localparam int S = 4;   // settle/release cycles
    localparam int G = 2;   // gap cycles

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [0:0] cmd_island;
    logic [5:0] cmd_row;
    logic [5:0] cmd_col;
    logic       cmd_op;
    logic [15:0] cmd_width;
    logic [7:0] cmd_count;
    logic       abort;
    logic [1:0] island_sel;
    logic [5:0] row_addr;
    logic [5:0] col_addr;
    logic       dec_en;
    logic       gate_mux_en;
    logic       drain_sel_en;
    logic       prog_mode;
    logic       vinj_pulse;
    logic       meas_strobe;
    logic       busy;
    logic       done;
    logic       err;
    logic       aborted;

    int total = 0;
    int bad   = 0;

    fg_prog_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_island   (cmd_island),
        .cmd_row      (cmd_row),
        .cmd_col      (cmd_col),
        .cmd_op       (cmd_op),
        .cmd_width    (cmd_width),
        .cmd_count    (cmd_count),
        .abort        (abort),
        .island_sel   (island_sel),
        .row_addr     (row_addr),
        .col_addr     (col_addr),
        .dec_en       (dec_en),
        .gate_mux_en  (gate_mux_en),
        .drain_sel_en (drain_sel_en),
        .prog_mode    (prog_mode),
        .vinj_pulse   (vinj_pulse),
        .meas_strobe  (meas_strobe),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .aborted      (aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // {island_sel, row, col, dec_en, gate_mux_en, drain_sel_en, prog_mode}
    function automatic logic [17:0] sel_bus();
        return {island_sel, row_addr, col_addr, dec_en, gate_mux_en, drain_sel_en, prog_mode};
    endfunction

    // {cmd_ready, busy, done, err, aborted}
    function automatic logic [4:0] stat_bus();
        return {cmd_ready, busy, done, err, aborted};
    endfunction

    // Issues one command (caller must be at a negedge with the DUT idle),
    // then checks every cycle until the first idle cycle after done.
    // abort_at: cycle number (1 = first cycle after acceptance) during which
    // abort is held high, or 0 for none. hold_valid keeps cmd_valid asserted.
    task automatic run_cmd(input logic isl, input int row, input int col, input logic op,
                           input int width, input int count, input int abort_at,
                           input bit hold_valid);
        int   w, act_end, cut, rel_end, done_cyc;
        bit   addr_bad, ab, sel_on, vinj_e, strobe_e;
        logic [17:0] sel_e;
        logic [1:0]  isl_oh;
        w        = (width == 0) ? 1 : width;
        addr_bad = (row >= 16) || (col >= 32);
        if (op)              act_end = S + w;
        else if (count > 0)  act_end = S + count * w + (count - 1) * G;
        else                 act_end = S;
        ab       = !addr_bad && abort_at >= 1 && abort_at <= act_end;
        cut      = ab ? abort_at : act_end;
        rel_end  = cut + S;
        done_cyc = addr_bad ? 1 : rel_end + 1;
        isl_oh   = isl ? 2'b10 : 2'b01;

        cmd_island = isl;
        cmd_row    = 6'(row);
        cmd_col    = 6'(col);
        cmd_op     = op;
        cmd_width  = 16'(width);
        cmd_count  = 8'(count);
        cmd_valid  = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= done_cyc + 1; k++) begin
            #1;
            abort = (k == abort_at);
            if (!hold_valid) cmd_valid = 1'b0;
            @(negedge clk);
            sel_on   = !addr_bad && k <= rel_end;
            vinj_e   = !addr_bad && !op && k > S && k <= cut && ((k - S - 1) % (w + G)) < w;
            strobe_e = !addr_bad && op && k == S + w && k <= cut;
            sel_e    = sel_on ? {isl_oh, 6'(row), 6'(col), 1'b1, 1'b1, ~op, 1'b1} : 18'd0;
            check_eq($sformatf("sel c%0d", k), 64'(sel_bus()), 64'(sel_e));
            check_eq($sformatf("pulse c%0d", k), 64'({vinj_pulse, meas_strobe}),
                     64'({vinj_e, strobe_e}));
            check_eq($sformatf("stat c%0d", k), 64'(stat_bus()),
                     64'({k == done_cyc + 1, k <= done_cyc, k == done_cyc,
                          k == done_cyc && addr_bad, k == done_cyc && ab}));
            if (k <= done_cyc) @(posedge clk);
        end
        abort = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_island = '0;
        cmd_row    = '0;
        cmd_col    = '0;
        cmd_op     = 1'b0;
        cmd_width  = '0;
        cmd_count  = '0;
        abort      = 1'b0;
        #2;
        check_eq("reset sel", 64'(sel_bus()), 64'd0);
        check_eq("reset pulse", 64'({vinj_pulse, meas_strobe}), 64'd0);
        check_eq("reset stat", 64'(stat_bus()), 64'b10000);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Directed cases
        run_cmd(1'b1, 5, 20, 1'b0, 3, 2, 0, 1'b0);    // inject, done cycle 17
        run_cmd(1'b0, 15, 31, 1'b1, 0, 7, 0, 1'b0);   // measure width 0, done cycle 10
        run_cmd(1'b1, 16, 3, 1'b0, 3, 2, 0, 1'b0);    // row out of range
        run_cmd(1'b0, 2, 40, 1'b0, 3, 2, 0, 1'b0);    // column out of range
        run_cmd(1'b0, 9, 11, 1'b0, 10, 3, 20, 1'b0);  // abort during second pulse
        run_cmd(1'b1, 1, 1, 1'b0, 5, 0, 0, 1'b1);     // count 0, valid held
        run_cmd(1'b0, 3, 4, 1'b0, 2, 1, 0, 1'b1);     // accepted back to back
        run_cmd(1'b1, 7, 9, 1'b1, 6, 0, 10, 1'b0);    // abort on the strobe cycle
        run_cmd(1'b0, 0, 0, 1'b0, 4, 2, 15, 1'b0);    // abort during release ignored

        // Randomized commands, some with aborts at arbitrary cycles
        for (int n = 0; n < 60; n++) begin
            int r, c, wd, cn, ab;
            logic op, isl;
            isl = 1'($urandom_range(0, 1));
            r   = int'($urandom_range(0, 18));
            c   = int'($urandom_range(0, 35));
            op  = 1'($urandom_range(0, 3) == 0);
            wd  = int'($urandom_range(0, 6));
            cn  = int'($urandom_range(0, 4));
            ab  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 30)) : 0;
            run_cmd(isl, r, c, op, wd, cn, ab, 1'($urandom_range(0, 1)));
        end
        cmd_valid = 1'b0;

        // Asynchronous reset in the middle of a pulse
        cmd_island = 1'b0;
        cmd_row    = 6'd3;
        cmd_col    = 6'd7;
        cmd_op     = 1'b0;
        cmd_width  = 16'd10;
        cmd_count  = 8'd3;
        cmd_valid  = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check_eq("pre-reset vinj", 64'(vinj_pulse), 64'd1);
        #2 reset = 1'b1;
        #1;
        check_eq("async reset sel", 64'(sel_bus()), 64'd0);
        check_eq("async reset pulse", 64'({vinj_pulse, meas_strobe}), 64'd0);
        check_eq("async reset stat", 64'(stat_bus()), 64'b10000);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check_eq($sformatf("post-reset stat %0d", k), 64'(stat_bus()), 64'b10000);
        end

        // Idle operation still works after the reset
        run_cmd(1'b1, 12, 30, 1'b0, 2, 3, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
